// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller and its datapath: state codes,
// opcodes, mux-select encodings and the packed control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ALUWB  = 4'd4,
    ST_MEMADR = 4'd5,
    ST_MEMRD  = 4'd6,
    ST_MEMWB  = 4'd7,
    ST_MEMWR  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_PCINC  = 4'd10,
    ST_JAL    = 4'd11,
    ST_JALR   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MEM    = 2'b01;
  localparam logic [1:0] M2R_PC4    = 2'b10;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       ir_write;
    logic       reg_write;
    logic       latch_ab;
    logic       alu_out_en;
    logic [1:0] pc_source;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       retire;
  } ctrl_t;

  // Dispatch out of DECODE; LUI lands in TRAP because ALU A has no zero source.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_R:      return ST_EXEC_R;
      OP_IMM:    return ST_EXEC_I;
      OP_LOAD:   return ST_MEMADR;
      OP_STORE:  return ST_MEMADR;
      OP_BRANCH: return ST_BRANCH;
      OP_JAL:    return ST_JAL;
      OP_JALR:   return ST_JALR;
      OP_AUIPC:  return ST_ALUWB;
      default:   return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode to immediate-format select; purely combinational, no latency, no backpressure.
module imm_sel_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_AUIPC:  imm_src = IMM_U;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the RV64 multicycle datapath: 3-5 cycles per instruction plus memory waits.
// Stalls in MEMRD/MEMWR until data_ready; a stalled request past MEM_TIMEOUT cycles traps for good.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       data_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       LatchAB,
  output logic       ALUOutEn,
  output logic [1:0] PCSource,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       retire,
  output logic       trap,
  output logic [3:0] state_o
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       timed_out;
  logic       trap_q;
  ctrl_t      ctrl;

  assign wait_inc  = wait_cnt + 8'd1;
  assign timed_out = (wait_inc == TIMEOUT);

  imm_sel_decode u_imm_sel (
    .opcode  (opcode),
    .imm_src (ImmSrc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= 8'd0;
      trap_q   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          state <= decode_next(opcode);
          if (decode_next(opcode) == ST_TRAP) trap_q <= 1'b1;
        end
        ST_EXEC_R: state <= ST_ALUWB;
        ST_EXEC_I: state <= ST_ALUWB;
        ST_MEMADR: begin
          // Only way into the wait states, so the counter restarts here.
          wait_cnt <= 8'd0;
          state    <= (opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
        end
        ST_MEMRD, ST_MEMWR: begin
          if (data_ready) begin
            state <= (state == ST_MEMRD) ? ST_MEMWB : ST_FETCH;
          end else if (timed_out) begin
            state  <= ST_TRAP;
            trap_q <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        ST_BRANCH: state <= br_taken ? ST_FETCH : ST_PCINC;
        ST_ALUWB, ST_MEMWB, ST_PCINC, ST_JAL, ST_JALR: state <= ST_FETCH;
        ST_TRAP:   state <= ST_TRAP;
        default: begin
          state  <= ST_TRAP;
          trap_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.ir_write = 1'b1;
        ctrl.ior_d    = 1'b0;
      end
      ST_DECODE: begin
        // Speculative PC+Imm for AUIPC; the other paths overwrite ALUOut later.
        ctrl.latch_ab   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_out_en = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_FUNCT;
        ctrl.alu_out_en = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_FUNCT;
        ctrl.alu_out_en = 1'b1;
      end
      ST_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_PC4;
        ctrl.retire     = 1'b1;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_out_en = 1'b1;
      end
      ST_MEMRD: begin
        ctrl.ior_d    = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      ST_MEMWB: begin
        // Request stays high so memory keeps driving the read data.
        ctrl.ior_d      = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MEM;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_PC4;
        ctrl.retire     = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_write = 1'b1;
        if (data_ready) begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_PC4;
          ctrl.retire    = 1'b1;
        end
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = SRCA_A;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = br_taken;
      end
      ST_PCINC: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_PC4;
        ctrl.retire    = 1'b1;
      end
      ST_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC4;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      ST_JALR: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC4;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JALR;
        ctrl.retire     = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Nothing reaches the datapath while reset is held, even though state reads FETCH.
    if (reset) ctrl = '0;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign LatchAB     = ctrl.latch_ab;
  assign ALUOutEn    = ctrl.alu_out_en;
  assign PCSource    = ctrl.pc_source;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign retire      = ctrl.retire;
  assign trap        = trap_q;
  assign state_o     = state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing controller for the RV64 multicycle datapath. It decodes the instruction opcode and steps the datapath through the fetch, decode, execute, memory and writeback cycles. It drives every mux select, latch enable and write strobe of the datapath. It handshakes with data memory through a request/ready pair with a timeout, and stops in a sticky trap on illegal opcodes or memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for data_ready before trap; 8-bit counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- opcode  in  7  instruction[6:0] from datapath
- br_taken  in  1  datapath branch-condition result for current funct3
- data_ready  in  1  data memory completes read/write this cycle
- PCWrite, PCWriteCond, IorD, IRWrite, RegWrite, LatchAB, ALUOutEn  out  1 each  datapath strobes/selects
- PCSource, MemtoReg, ALUOp, ALUSrcA, ALUSrcB  out  2 each  datapath selects
- ImmSrc  out  3  immediate format
- MemRead, MemWrite  out  1 each  data memory request
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- trap  out  1  sticky fault flag
- state_o  out  4  current state code, debug

## Operation
- Encodings:
  - ALUSrcA: 00 PC, 01 A.
  - ALUSrcB: 00 B, 01 const 4, 10 Imm.
  - ALUOp: 00 add, 01 sub/compare, 10 funct-decoded.
  - MemtoReg: 00 ALUOut, 01 mem data, 10 PC+4.
  - PCSource: 00 PC+4, 01 ALUOut, 10 ALUResult with LSB cleared.
  - IorD: 0 PC, 1 ALUOut.
  - ImmSrc: 000 I, 001 S, 010 B, 011 U, 100 J.
- ImmSrc is combinationally decoded from opcode in every state:
  - load/OP-IMM/JALR → I; store → S; branch → B; AUIPC → U; JAL → J; other → I.
- Unlisted outputs are 0 in every state.
- Opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111.
  - Anything else, LUI included (no zero source for ALU A), → TRAP.
- The PC advances only in the final state of each instruction, so every state sees the instruction's own PC.
- State actions and transitions:
  - FETCH: IRWrite=1, IorD=0 → DECODE.
  - DECODE: LatchAB=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ALUOutEn=1 (ALUOut=PC+Imm). Next state by opcode: R→EXEC_R, OP-IMM→EXEC_I, LOAD/STORE→MEMADR, BRANCH→BRANCH, JAL→JAL, JALR→JALR, AUIPC→ALUWB, else TRAP.
  - EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10, ALUOutEn=1 → ALUWB.
  - EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=10, ALUOutEn=1 → ALUWB.
  - ALUWB: RegWrite=1, MemtoReg=00, PCWrite=1, PCSource=00, retire → FETCH.
  - MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ALUOutEn=1 → MEMRD (load) / MEMWR (store).
  - MEMRD: IorD=1, MemRead=1. If data_ready → MEMWB; else wait.
  - MEMWB: IorD=1, MemRead=1 (memory holds data while request is high), RegWrite=1, MemtoReg=01, PCWrite=1, PCSource=00, retire → FETCH.
  - MEMWR: IorD=1, MemWrite=1. On data_ready: PCWrite=1, PCSource=00, retire → FETCH; else wait.
  - BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. If br_taken: retire → FETCH; else → PCINC.
  - PCINC: PCWrite=1, PCSource=00, retire → FETCH.
  - JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01, retire → FETCH.
  - JALR: ALUSrcA=01, ALUSrcB=10, ALUOp=00, RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=10, retire → FETCH.
  - TRAP: all strobes 0, trap=1; stays until reset.
- Wait counter:
  - Clears on entry to MEMRD/MEMWR; increments each cycle data_ready is low.
  - Reaching MEM_TIMEOUT → TRAP, with MemRead/MemWrite dropped in TRAP.

## Timing
- Reset: state=FETCH, wait counter=0, trap=0. While reset is high, every strobe and memory request is forced 0. The first IRWrite is on the first clk edge after release.
- Outputs are combinational from state, plus data_ready/br_taken for the wait and branch states; no output registers.
- Cycles per instruction, with data_ready high on the first request cycle:
  - R/OP-IMM: 4
  - LOAD: 5
  - STORE: 4
  - taken branch: 3; not-taken branch: 4
  - JAL/JALR/AUIPC: 3
  - Each extra wait cycle adds 1 to LOAD/STORE.
- data_ready outside MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction aborts immediately; no partial register or PC write completes.

## Structure
- Package mc_pkg:
  - state enum (4-bit)
  - opcode localparams
  - ALUSrcA/ALUSrcB/ALUOp/MemtoReg/PCSource/ImmSrc encodings, shared with the datapath
- Sub-module imm_sel_decode: combinational opcode→ImmSrc map, reused by the datapath bench.
- FSM state register, wait counter, and trap flag are in the top module.

## Test plan
- add x3,x1,x2 (0x002081B3): states FETCH,DECODE,EXEC_R,ALUWB. RegWrite=1 and PCWrite=1 only in cycle 4. retire pulses once.
- ld with data_ready low for 3 cycles: MEMRD held 4 cycles with MemRead=1, IorD=1. MEMWB on the 5th. Total 8 cycles, MemtoReg=01.
- beq with br_taken=1 → 3 cycles, PCWriteCond=1, PCSource=01. With br_taken=0 → PCINC, PCWrite=1, PCSource=00, 4 cycles.
- jalr x1,0(x5): cycle 3 has PCSource=10, MemtoReg=10, RegWrite=1, PCWrite=1, all simultaneous.
- Store with data_ready never asserted: after 255 wait cycles → TRAP, trap=1, MemWrite=0, stays until reset.
- Opcode 0110111 (LUI) → TRAP after DECODE. Reset asserted during MEMRD → next state FETCH, no RegWrite pulse.
